// File: rtl/serial_subtractor_nbits_pkg.sv
// serial_subtractor_nbits_pkg: FSM state encoding and counter width helper for the serial subtractor
package serial_subtractor_nbits_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  function automatic int cnt_width(input int size);
    return (size < 2) ? 1 : $clog2(size);
  endfunction
endpackage

// File: rtl/serial_subtractor_nbits_if.sv
// serial_subtractor_nbits_if: operand/result valid-ready bundle
// master: producer/consumer side (drives in_valid, a, b, bin, out_ready)
// slave: subtractor side (drives in_ready, out_valid, diff, bout, ovf)
interface serial_subtractor_nbits_if #(parameter int SIZE = 4);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            bin;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] diff;
  logic            bout;
  logic            ovf;
  modport master (output in_valid, a, b, bin, out_ready, input in_ready, out_valid, diff, bout, ovf);
  modport slave (input in_valid, a, b, bin, out_ready, output in_ready, out_valid, diff, bout, ovf);
endinterface

// File: rtl/serial_subtractor_nbits_cell.sv
// fullsubtractor_1bit_in_nor: NOR-only 1-bit full subtractor
// ports: a, b, bin in; diff = a^b^bin, bout = (~a&b) | (~(a^b)&bin) out
module fullsubtractor_1bit_in_nor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  logic n1, n2, n3, x1, m1, m2, m3, nx1, nbin, p, q;
  // x1 = xnor(a, b); n2 = ~a & b
  assign n1 = ~(a | b);
  assign n2 = ~(a | n1);
  assign n3 = ~(b | n1);
  assign x1 = ~(n2 | n3);
  // xnor(xnor(a, b), bin) = a ^ b ^ bin
  assign m1 = ~(x1 | bin);
  assign m2 = ~(x1 | m1);
  assign m3 = ~(bin | m1);
  assign diff = ~(m2 | m3);
  // p = x1 & bin
  assign nx1 = ~(x1 | x1);
  assign nbin = ~(bin | bin);
  assign p = ~(nx1 | nbin);
  assign q = ~(n2 | p);
  assign bout = ~(q | q);
endmodule

// File: rtl/serial_subtractor_nbits.sv
// serial_subtractor_nbits: bit-serial a - b - bin, LSB first, one NOR cell plus registered borrow
// ports: clk, rst_n (async active-low), bus (slave modport: operand and result handshakes)
module serial_subtractor_nbits
  import serial_subtractor_nbits_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic clk,
  input  logic rst_n,
  serial_subtractor_nbits_if.slave bus
);
  localparam int CW = cnt_width(SIZE);
  state_t          state, next;
  logic [CW-1:0]   cnt;
  logic [SIZE-1:0] sa, sb, sd;
  logic            br, bo, ov, am, bm, d, nb, last;
  fullsubtractor_1bit_in_nor u_cell (.a(sa[0]), .b(sb[0]), .bin(br), .diff(d), .bout(nb));
  assign last = cnt == CW'(SIZE - 1);
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.diff = sd;
  assign bus.bout = bo;
  assign bus.ovf = ov;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = IDLE;
    next = (state == IDLE) ? (bus.in_valid ? CALC : IDLE) :
           (state == CALC) ? (last ? DONE : CALC) :
           (state == DONE) ? (bus.out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      sa <= '0;
      sb <= '0;
      sd <= '0;
      br <= 1'b0;
      bo <= 1'b0;
      ov <= 1'b0;
      am <= 1'b0;
      bm <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      sa <= bus.a;
      sb <= bus.b;
      br <= bus.bin;
      cnt <= '0;
      am <= bus.a[SIZE-1];
      bm <= bus.b[SIZE-1];
    end else if (state == CALC) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      sd <= {d, sd[SIZE-1:1]};
      br <= nb;
      cnt <= cnt + 1'b1;
      if (last) begin
        bo <= nb;
        // d is the final (MSB) difference bit here
        ov <= (am != bm) && (d != am);
      end
    end
endmodule
